// File: rtl/arbiter_v2.sv
// arbiter_v2: single-port RAM arbiter for fetch, line drawer and circle drawer
// Ports: clk, rst_ (sync, active-high); per engine *_rts_in, *_rtr_out, *_op, *_addr, *_wrdata;
//   en_fetching gates the fetcher; RAM side wben, mem_addr, mem_data_out, mem_data_in;
//   read return on bcast_data with one-hot bcast_xfc_out strobe one cycle after grant.
// Define ARB_FIXED_PRIORITY_EN for fixed priority fetch > linedrawer > circledrawer.
module arbiter_v2 #(
   parameter int NUM_ENGINES = 2
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic                 en_fetching,
   input  logic                 fetch_rts_in,
   output logic                 fetch_rtr_out,
   input  logic [3:0]           fetch_op,
   input  logic [16:0]          fetch_addr,
   input  logic [31:0]          fetch_wrdata,
   input  logic                 linedrawer_rts_in,
   output logic                 linedrawer_rtr_out,
   input  logic [3:0]           linedrawer_op,
   input  logic [16:0]          linedrawer_addr,
   input  logic [31:0]          linedrawer_wrdata,
   input  logic                 circledrawer_rts_in,
   output logic                 circledrawer_rtr_out,
   input  logic [3:0]           circledrawer_op,
   input  logic [16:0]          circledrawer_addr,
   input  logic [31:0]          circledrawer_wrdata,
   output logic [3:0]           wben,
   output logic [16:0]          mem_addr,
   input  logic [31:0]          mem_data_in,
   output logic [31:0]          mem_data_out,
   output logic [31:0]          bcast_data,
   output logic [NUM_ENGINES:0] bcast_xfc_out
);
   logic [2:0] elig, sel;
   logic [1:0] start, gnt_idx, rd_idx_q, rd_idx_d;
   logic gnt_v, gv, rd_q, rd_d;
   logic [3:0] g_op;
   logic [16:0] g_addr, addr_q, addr_d;
   logic [31:0] g_wd, data_q, data_d, bcast_q, bcast_d;
   always_comb begin
      elig = {circledrawer_rts_in, linedrawer_rts_in, fetch_rts_in & en_fetching};
      sel = 3'd0;
      gnt_v = 1'b0;
      gnt_idx = 2'd0;
      // scan from the far end so the requester nearest the start slot wins last
      for (int k = 2; k >= 0; k--) begin
         sel = {1'b0, start} + 3'(k);
         sel = sel >= 3'd3 ? sel - 3'd3 : sel;
         if (elig[sel[1:0]]) begin
            gnt_v = 1'b1;
            gnt_idx = sel[1:0];
         end
      end
      gv = gnt_v & ~rst_;
      g_op = gnt_idx == 2'd0 ? fetch_op : gnt_idx == 2'd1 ? linedrawer_op : circledrawer_op;
      g_addr = gnt_idx == 2'd0 ? fetch_addr : gnt_idx == 2'd1 ? linedrawer_addr : circledrawer_addr;
      g_wd = gnt_idx == 2'd0 ? fetch_wrdata : gnt_idx == 2'd1 ? linedrawer_wrdata : circledrawer_wrdata;
      fetch_rtr_out = gv & (gnt_idx == 2'd0);
      linedrawer_rtr_out = gv & (gnt_idx == 2'd1);
      circledrawer_rtr_out = gv & (gnt_idx == 2'd2);
      wben = gv ? g_op : 4'd0;
      mem_addr = rst_ ? 17'd0 : gv ? g_addr : addr_q;
      mem_data_out = rst_ ? 32'd0 : gv ? g_wd : data_q;
      addr_d = mem_addr;
      data_d = mem_data_out;
      rd_d = gv & (g_op == 4'd0);
      rd_idx_d = gnt_idx;
      bcast_d = rd_q ? mem_data_in : bcast_q;
      bcast_data = rst_ ? 32'd0 : bcast_d;
      bcast_xfc_out = '0;
      for (int j = 0; j <= NUM_ENGINES && j < 3; j++)
         bcast_xfc_out[j] = ~rst_ & rd_q & (rd_idx_q == 2'(j));
   end
   always_ff @(posedge clk) begin
      if (rst_) begin
         addr_q <= 17'd0;
         data_q <= 32'd0;
         bcast_q <= 32'd0;
         rd_q <= 1'b0;
         rd_idx_q <= 2'd0;
      end else begin
         addr_q <= addr_d;
         data_q <= data_d;
         bcast_q <= bcast_d;
         rd_q <= rd_d;
         rd_idx_q <= rd_idx_d;
      end
   end
`ifdef ARB_FIXED_PRIORITY_EN
   assign start = 2'd0;
`else
   logic [1:0] ptr_q, ptr_d;
   assign start = ptr_q;
   always_comb ptr_d = gv ? (gnt_idx == 2'd2 ? 2'd0 : gnt_idx + 2'd1) : ptr_q;
   always_ff @(posedge clk) begin
      if (rst_) ptr_q <= 2'd0;
      else ptr_q <= ptr_d;
   end
`endif
endmodule

// File: tb/tb_arbiter_v2.sv
// tb_arbiter_v2: self-checking bench for arbiter_v2
module tb_arbiter_v2;
   logic clk = 1'b0, rst_ = 1'b1, en_fetching = 1'b0;
   logic f_rts = 1'b0, l_rts = 1'b0, c_rts = 1'b0;
   logic f_rtr, l_rtr, c_rtr;
   logic [3:0] f_op = 4'd0, l_op = 4'd0, c_op = 4'd0, wben;
   logic [16:0] f_addr = 17'd0, l_addr = 17'd0, c_addr = 17'd0, mem_addr;
   logic [31:0] f_wd = 32'd0, l_wd = 32'd0, c_wd = 32'd0, mem_data_in = 32'd0, mem_data_out, bcast_data;
   logic [2:0] bcast_xfc_out;
   int n_chk = 0, n_pass = 0, cyc = 0;
   int m_ptr = 0, m_pend = -1;
   logic [16:0] m_addr = 17'd0;
   logic [31:0] m_data = 32'd0, m_bcast = 32'd0;

   arbiter_v2 #(.NUM_ENGINES(2)) dut (
      .clk(clk), .rst_(rst_), .en_fetching(en_fetching),
      .fetch_rts_in(f_rts), .fetch_rtr_out(f_rtr), .fetch_op(f_op), .fetch_addr(f_addr), .fetch_wrdata(f_wd),
      .linedrawer_rts_in(l_rts), .linedrawer_rtr_out(l_rtr), .linedrawer_op(l_op),
      .linedrawer_addr(l_addr), .linedrawer_wrdata(l_wd),
      .circledrawer_rts_in(c_rts), .circledrawer_rtr_out(c_rtr), .circledrawer_op(c_op),
      .circledrawer_addr(c_addr), .circledrawer_wrdata(c_wd),
      .wben(wben), .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
      .bcast_data(bcast_data), .bcast_xfc_out(bcast_xfc_out)
   );

   always #5 clk = ~clk;

   // RAM read data stand-in: a fresh, recognisable word every cycle
   always @(posedge clk) begin
      cyc <= cyc + 1;
      mem_data_in <= 32'hDA7A0000 + 32'(cyc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // reference model: grant = first eligible requester from the pointer, read data one cycle later
   always @(negedge clk) begin : model
      logic [2:0] elig, e_rtr, e_xfc;
      logic [3:0] ops [3];
      logic [16:0] adrs [3];
      logic [31:0] wds [3];
      int win;
      ops = '{f_op, l_op, c_op};
      adrs = '{f_addr, l_addr, c_addr};
      wds = '{f_wd, l_wd, c_wd};
      elig = {c_rts, l_rts, f_rts & en_fetching};
      win = -1;
      if (!rst_)
         for (int k = 0; k < 3; k++)
            if (win < 0 && elig[(m_ptr + k) % 3]) win = (m_ptr + k) % 3;
      e_rtr = win < 0 ? 3'b000 : 3'(1 << win);
      e_xfc = (!rst_ && m_pend >= 0) ? 3'(1 << m_pend) : 3'b000;
      chk("rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'(e_rtr));
      chk("wben", 32'(wben), win < 0 ? 32'd0 : 32'(ops[win]));
      chk("mem_addr", 32'(mem_addr), rst_ ? 32'd0 : win < 0 ? 32'(m_addr) : 32'(adrs[win]));
      chk("mem_data_out", mem_data_out, rst_ ? 32'd0 : win < 0 ? m_data : wds[win]);
      chk("bcast_data", bcast_data, rst_ ? 32'd0 : m_pend >= 0 ? mem_data_in : m_bcast);
      chk("bcast_xfc_out", 32'(bcast_xfc_out), 32'(e_xfc));
      if (rst_) begin
         m_ptr = 0;
         m_pend = -1;
         m_addr = 17'd0;
         m_data = 32'd0;
         m_bcast = 32'd0;
      end else begin
         if (m_pend >= 0) m_bcast = mem_data_in;
         m_pend = (win >= 0 && ops[win] == 4'd0) ? win : -1;
         if (win >= 0) begin
            m_addr = adrs[win];
            m_data = wds[win];
`ifndef ARB_FIXED_PRIORITY_EN
            m_ptr = (win + 1) % 3;
`endif
         end
      end
   end

   initial begin
      @(negedge clk);
      chk("reset rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'd0);
      chk("reset xfc", 32'(bcast_xfc_out), 32'd0);
      chk("reset mem_addr", 32'(mem_addr), 32'd0);
      chk("reset bcast_data", bcast_data, 32'd0);
      @(posedge clk); #1;
      rst_ = 1'b0;
      en_fetching = 1'b1;
`ifdef ARB_FIXED_PRIORITY_EN
      f_rts = 1'b1; l_rts = 1'b1; c_rts = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("fixed rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'b001);
      end
`else
      f_rts = 1'b1; l_rts = 1'b1; l_addr = 17'd2;
      @(negedge clk);
      chk("rr1 rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'b001);
      chk("rr1 addr", 32'(mem_addr), 32'd0);
      @(negedge clk);
      chk("rr2 rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'b010);
      chk("rr2 addr", 32'(mem_addr), 32'd2);
      chk("rr2 xfc", 32'(bcast_xfc_out), 32'b001);
      @(negedge clk);
      chk("rr3 rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'b001);
      chk("rr3 xfc", 32'(bcast_xfc_out), 32'b010);
      @(posedge clk); #1;
      f_rts = 1'b0; l_rts = 1'b0;
      c_rts = 1'b1; c_op = 4'hf; c_addr = 17'd1; c_wd = 32'hffff_ffff;
      @(negedge clk);
      chk("wr rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'b100);
      chk("wr wben", 32'(wben), 32'hf);
      chk("wr addr", 32'(mem_addr), 32'd1);
      chk("wr data", mem_data_out, 32'hffff_ffff);
      chk("wr overlap xfc", 32'(bcast_xfc_out), 32'b001);
      @(posedge clk); #1;
      c_rts = 1'b0;
      @(negedge clk);
      chk("wr no pulse", 32'(bcast_xfc_out), 32'd0);
      chk("idle wben", 32'(wben), 32'd0);
      chk("idle addr hold", 32'(mem_addr), 32'd1);
      chk("idle data hold", mem_data_out, 32'hffff_ffff);
      @(posedge clk); #1;
      en_fetching = 1'b0; f_rts = 1'b1; l_rts = 1'b1; c_rts = 1'b1; c_op = 4'd0; c_addr = 17'd3;
      @(negedge clk);
      chk("nofetch rtr1", 32'({c_rtr, l_rtr, f_rtr}), 32'b010);
      @(negedge clk);
      chk("nofetch rtr2", 32'({c_rtr, l_rtr, f_rtr}), 32'b100);
      @(negedge clk);
      chk("nofetch rtr3", 32'({c_rtr, l_rtr, f_rtr}), 32'b010);
      @(posedge clk); #1;
      rst_ = 1'b1;
      @(negedge clk);
      chk("rst xfc", 32'(bcast_xfc_out), 32'd0);
      chk("rst rtr", 32'({c_rtr, l_rtr, f_rtr}), 32'd0);
      chk("rst bcast", bcast_data, 32'd0);
      @(posedge clk); #1;
      rst_ = 1'b0; f_rts = 1'b0; l_rts = 1'b0; c_rts = 1'b0;
      @(negedge clk);
      chk("dropped read", 32'(bcast_xfc_out), 32'd0);
`endif
      repeat (60) begin
         @(posedge clk); #1;
         rst_ = $urandom_range(0, 24) == 0;
         en_fetching = 1'($urandom_range(0, 1));
         f_rts = 1'($urandom_range(0, 1));
         l_rts = 1'($urandom_range(0, 1));
         c_rts = 1'($urandom_range(0, 1));
         f_op = $urandom_range(0, 2) == 0 ? 4'($urandom_range(1, 15)) : 4'd0;
         l_op = $urandom_range(0, 2) == 0 ? 4'($urandom_range(1, 15)) : 4'd0;
         c_op = $urandom_range(0, 2) == 0 ? 4'($urandom_range(1, 15)) : 4'd0;
         f_addr = 17'($urandom);
         l_addr = 17'($urandom);
         c_addr = 17'($urandom);
         f_wd = $urandom;
         l_wd = $urandom;
         c_wd = $urandom;
      end
      @(posedge clk); #1;
      rst_ = 1'b0; f_rts = 1'b0; l_rts = 1'b0; c_rts = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
